// File: rtl/msk_stream_pkg.sv
// rtl/msk_stream_pkg.sv - shared types, widths and waveform math for the MSK stream modulator
package msk_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam real PI = 3.14159265358979323846;

    // Counter width that never collapses to zero bits (DATA_W may be 1).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Plain Taylor series so the table can be built by any elaborator,
    // independent of math-library support in constant functions.
    function automatic real msk_sin(input real x);
        real r;
        real term;
        real sum;
        r = x;
        if (r > PI) r = r - 2.0 * PI;
        term = r;
        sum  = r;
        for (int i = 1; i < 14; i++) begin
            term = -term * r * r / (real'(2 * i) * real'(2 * i + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // One offset-binary sample: bit 1 spans half a sine period over the
    // symbol, bit 0 a full period; phase pi flips the sine term.
    function automatic int msk_sample(input int bit_v, input int phase_v,
                                      input int k, input int n, input int sw);
        int  mid;
        real amp;
        real ang;
        real s;
        mid = 1 << (sw - 1);
        if (k >= n) return mid;
        amp = real'(mid - 1);
        ang = ((bit_v != 0) ? PI : 2.0 * PI) * real'(k) / real'(n - 1);
        s   = msk_sin(ang);
        if (phase_v != 0) s = -s;
        return $rtoi(real'(mid) + amp * s + 0.5);
    endfunction

endpackage

// File: rtl/msk_wave_rom.sv
// rtl/msk_wave_rom.sv - registered waveform lookup addressed by {bit, phase, k}
// Ports: clk_i/rst_ni clock and async active-low reset, en_i clock enable,
// mid_i loads the idle level, bit_i/phase_i/k_i table address, sample_o registered sample.
module msk_wave_rom
    import msk_stream_pkg::*;
#(
    parameter int N        = 32,
    parameter int SAMPLE_W = 8,
    parameter int KW       = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                mid_i,
    input  logic                bit_i,
    input  logic                phase_i,
    input  logic [KW-1:0]       k_i,
    output logic [SAMPLE_W-1:0] sample_o
);

    localparam int DEPTH = 4 << KW;
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [SAMPLE_W-1:0] wave_tab [DEPTH];
    logic [KW+1:0]       addr;
    logic [SAMPLE_W-1:0] sample_q;

    for (genvar a = 0; a < DEPTH; a++) begin : g_tab
        localparam int B = a >> (KW + 1);
        localparam int P = (a >> KW) & 1;
        localparam int K = a & ((1 << KW) - 1);
        assign wave_tab[a] = SAMPLE_W'(msk_sample(B, P, K, N, SAMPLE_W));
    end

    assign addr = {bit_i, phase_i, k_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q <= MID;
        end else if (en_i) begin
            sample_q <= mid_i ? MID : wave_tab[addr];
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/msk_modulator_stream.sv
// rtl/msk_modulator_stream.sv - gapless LSB-first MSK modulator with valid/ready word input
// Ports: g_clk_tx clock, reset async active-low, enable clock enable,
// data_in/data_valid/data_ready word handshake, sample_out/sample_valid/word_last
// sample stream, busy while a word is being modulated.
module msk_modulator_stream
    import msk_stream_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int SAMPLES_PER_BIT = 32,
    parameter int SAMPLE_W        = 8
) (
    input  logic                g_clk_tx,
    input  logic                reset,
    input  logic                enable,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                word_last,
    output logic                busy
);

    localparam int KW = idx_width(SAMPLES_PER_BIT);
    localparam int BW = idx_width(DATA_W);
    localparam logic [KW-1:0] K_LAST = KW'(SAMPLES_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [BW-1:0]       bit_idx_q, bit_idx_d;
    logic [KW-1:0]       k_q, k_d;
    logic                phase_q, phase_d;
    logic                prev_bit_q, prev_bit_d;
    logic                ready_en_q;

    logic                cur_bit;
    logic                bit_end;
    logic                word_end;
    logic                accept;
    logic                rom_mid;
    logic                rom_bit;
    logic                rom_phase;
    logic [KW-1:0]       rom_k;

    // Counters describe the sample currently on sample_out; the ROM address
    // below is the sample that will be shown after the next enabled edge.
    assign cur_bit    = word_q[bit_idx_q];
    assign bit_end    = (k_q == K_LAST);
    assign word_end   = (state_q == SEND) && bit_end && (bit_idx_q == B_LAST);
    assign data_ready = ready_en_q && ((state_q == IDLE) || word_end);
    assign accept     = enable && data_valid && data_ready;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        bit_idx_d  = bit_idx_q;
        k_d        = k_q;
        phase_d    = phase_q;
        prev_bit_d = prev_bit_q;
        rom_mid    = 1'b0;
        rom_bit    = cur_bit;
        rom_phase  = phase_q;
        rom_k      = k_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SEND;
                    word_d    = data_in;
                    bit_idx_d = '0;
                    k_d       = '0;
                    phase_d   = phase_q ^ prev_bit_q;
                    rom_bit   = data_in[0];
                    rom_phase = phase_d;
                    rom_k     = '0;
                end else begin
                    rom_mid = 1'b1;
                end
            end
            SEND: begin
                if (!bit_end) begin
                    k_d   = k_q + 1'b1;
                    rom_k = k_d;
                end else begin
                    prev_bit_d = cur_bit;
                    if (bit_idx_q != B_LAST) begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        k_d       = '0;
                        phase_d   = phase_q ^ cur_bit;
                        rom_bit   = word_q[bit_idx_d];
                        rom_phase = phase_d;
                        rom_k     = '0;
                    end else if (accept) begin
                        // Gapless hand-over: next word starts on the very next sample.
                        word_d    = data_in;
                        bit_idx_d = '0;
                        k_d       = '0;
                        phase_d   = phase_q ^ cur_bit;
                        rom_bit   = data_in[0];
                        rom_phase = phase_d;
                        rom_k     = '0;
                    end else begin
                        // Phase is left as the last bit's; the toggle is applied
                        // from prev_bit when the next word is accepted in IDLE.
                        state_d = IDLE;
                        rom_mid = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                rom_mid = 1'b1;
            end
        endcase
    end

    always_ff @(posedge g_clk_tx or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            bit_idx_q  <= '0;
            k_q        <= '0;
            phase_q    <= 1'b0;
            prev_bit_q <= 1'b0;
            ready_en_q <= 1'b0;
        end else if (enable) begin
            state_q    <= state_d;
            word_q     <= word_d;
            bit_idx_q  <= bit_idx_d;
            k_q        <= k_d;
            phase_q    <= phase_d;
            prev_bit_q <= prev_bit_d;
            ready_en_q <= 1'b1;
        end
    end

    msk_wave_rom #(
        .N        (SAMPLES_PER_BIT),
        .SAMPLE_W (SAMPLE_W),
        .KW       (KW)
    ) u_rom (
        .clk_i    (g_clk_tx),
        .rst_ni   (reset),
        .en_i     (enable),
        .mid_i    (rom_mid),
        .bit_i    (rom_bit),
        .phase_i  (rom_phase),
        .k_i      (rom_k),
        .sample_o (sample_out)
    );

    assign busy         = (state_q == SEND);
    assign sample_valid = busy;
    assign word_last    = word_end;

endmodule

// File: doc/msk_modulator_stream.md
Name: msk_modulator_stream

Overview:
Parametrised MSK modulator for the TX path. Accepts data words over a valid/ready handshake and serialises them LSB-first. Each bit is emitted as SAMPLES_PER_BIT unsigned sine samples, one per g_clk_tx cycle. Phase is continuous across words, and back-to-back words stream with no gap, feeding the DAC interface downstream.

Parameters:
DATA_W, 8, bits per input word (1..32)
SAMPLES_PER_BIT, 32, samples per symbol (4..256)
SAMPLE_W, 8, output sample width (4..16)

Ports:
g_clk_tx  in  1  TX clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  clock enable; low freezes all state and outputs
data_in  in  DATA_W  word to modulate, sampled on handshake
data_valid  in  1  data_in valid
data_ready  out  1  block can accept a word this cycle
sample_out  out  SAMPLE_W  modulated sample, unsigned offset-binary
sample_valid  out  1  sample_out is a live sample
word_last  out  1  high with the final sample of a word
busy  out  1  a word is being modulated

Behaviour:
- Constants: MID = 2^(SAMPLE_W-1); AMP = MID-1; N = SAMPLES_PER_BIT; k = 0..N-1.
- Four waveform tables, one per (bit, phase):
  - bit0/phase0: MID + AMP*sin(2πk/(N-1)).
  - bit1/phase0: MID + AMP*sin(πk/(N-1)).
  - phase π: the same with the sine term negated.
  - All values rounded to nearest. For the 8/32 defaults: bit0/ph0 starts 128,154,178,201; bit1/ph0 starts 128,141,154,166; bit0/phπ starts 128,102,78,55. k=0 and k=N-1 are always MID.
- Phase rule: before each bit, phase toggles if the previously transmitted bit was 1. "Previous bit" carries across word boundaries (the last bit of word n governs the first bit of word n+1).
- Reset values: phase=0, prev_bit=0, sample_out=MID, sample_valid=0, word_last=0, busy=0, data_ready=0. data_ready rises on the first enabled cycle after reset.
- FSM states:
  - IDLE: data_ready=1, sample_valid=0, sample_out=MID. On data_valid&data_ready&enable: latch word, bit_idx=0, k=0, go to SEND.
  - SEND: each enabled cycle outputs table[bit][phase][k] registered, with sample_valid=1.
    - k wraps at N-1, then bit_idx increments and the phase rule is applied.
    - After bit DATA_W-1, k=N-1: word_last=1.
    - If a new handshake occurs in that same cycle, stay in SEND at bit_idx=0, k=0 (gapless); otherwise go to IDLE.
- Latency: first sample appears the cycle after the handshake.
- data_ready is high in IDLE and in SEND only on the cycle presenting the last sample of the word.
- Handshake with enable=0 is not accepted.
- enable low mid-word: outputs hold their last values and counters freeze; resume exactly where stopped.
- Reset asserted mid-word: word is dropped and everything returns to reset values immediately (async). Phase history is cleared.
- data_in changes while busy are ignored; only the latched copy is used.
- busy = (state==SEND).

Decomposition:
- Package msk_stream_pkg holds:
  - state enum (IDLE, SEND);
  - constant function computing a waveform sample from (bit, phase, k, N, SAMPLE_W) at elaboration, using real math;
  - derived widths clog2(N) and clog2(DATA_W).
- Sub-module msk_wave_rom: parametrised, registered lookup addressed by {bit, phase, k}, table built at elaboration from the package function. The top holds the FSM, counters and phase logic.

Test Plan:
- Reset / idle: reset low then high, no stimulus -> sample_out=128, sample_valid=0, busy=0, data_ready=1 after first enabled cycle.
- Word 0x00: send 0x00 -> 256 valid samples, each 32-block = 128,154,178,201,...; phase stays 0; word_last on sample 255 only.
- Word 0x01: send 0x01 -> bit0 block starts 128,141,154; bit1 (phase toggled) block starts 128,102,78,55.
- Cross-word phase: send 0x80 then 0x00 back-to-back -> no idle cycle between words; second word's first block starts 128,102,78 (phase π).
- Enable stall: drop enable for 5 cycles at sample 40 of a word -> sample_out and counters held; sequence resumes at sample 41 unchanged.
- Reset mid-word: assert reset at sample 100 -> immediate sample_valid=0, sample_out=128. Then sending 0x00 yields phase-0 waveform (history cleared).
